// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: segment/anode driver behind the Gray-coded 4-digit scan FSM, with a
// frame-aligned double-buffered hex value, anti-ghost blanking and a sel/digi consistency check.
// Optional build macro: LEADING_ZERO_BLANK_EN (suppress leading zero digits 4..2).
module seg7_scan_driver #(
  parameter int unsigned BLANK_CYC      = 2,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_ni,
  input  logic [1:0]  sel,
  input  logic [3:0]  digi,
  input  logic [15:0] data_i,
  input  logic [3:0]  dp_i,
  input  logic        load_i,
  output logic        pending_o,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic [3:0]  an_o,
  output logic        err_o
);

  // The change edge itself is the first blank cycle, so the counter only holds the remainder.
  localparam int unsigned      CNT_W      = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [CNT_W-1:0] BLANK_LOAD = (BLANK_CYC > 0) ? CNT_W'(BLANK_CYC - 1) : '0;
  localparam logic             BLANK_EN   = (BLANK_CYC != 0);
  localparam logic [6:0]       SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic             DP_OFF     = SEG_ACTIVE_LOW;
  localparam logic [1:0]       SEL_LAST   = 2'b10;
  localparam logic [1:0]       SEL_FIRST  = 2'b00;

  logic [15:0]      disp_q;
  logic [3:0]       disp_dp_q;
  logic [15:0]      pend_q;
  logic [3:0]       pend_dp_q;
  logic [1:0]       prev_sel_q;
  logic [CNT_W-1:0] blank_cnt_q;

  logic [1:0]       digit_idx;
  logic [3:0]       exp_digi;
  logic             mismatch;
  logic             sel_change;
  logic             frame_start;
  logic             commit;
  logic             blank_now;
  logic [CNT_W-1:0] blank_cnt_nxt;
  logic [15:0]      disp_nxt;
  logic [3:0]       disp_dp_nxt;
  logic [3:0]       nibble;
  logic             dp_req;
  logic [6:0]       seg_lit;
  logic [3:0]       lz_mask;
  logic             lz_hide;

  function automatic logic [1:0] digit_of(input logic [1:0] s);
    case (s)
      2'b00:   digit_of = 2'd0;
      2'b01:   digit_of = 2'd1;
      2'b11:   digit_of = 2'd2;
      default: digit_of = 2'd3;
    endcase
  endfunction

  // Active-low pattern, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_seg_n(input logic [3:0] v);
    case (v)
      4'h0:    hex_seg_n = 7'b1000000;
      4'h1:    hex_seg_n = 7'b1111001;
      4'h2:    hex_seg_n = 7'b0100100;
      4'h3:    hex_seg_n = 7'b0110000;
      4'h4:    hex_seg_n = 7'b0011001;
      4'h5:    hex_seg_n = 7'b0010010;
      4'h6:    hex_seg_n = 7'b0000010;
      4'h7:    hex_seg_n = 7'b1111000;
      4'h8:    hex_seg_n = 7'b0000000;
      4'h9:    hex_seg_n = 7'b0010000;
      4'hA:    hex_seg_n = 7'b0001000;
      4'hB:    hex_seg_n = 7'b0000011;
      4'hC:    hex_seg_n = 7'b1000110;
      4'hD:    hex_seg_n = 7'b0100001;
      4'hE:    hex_seg_n = 7'b0000110;
      default: hex_seg_n = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    digit_idx   = digit_of(sel);
    exp_digi    = 4'b0001 << digit_idx;
    mismatch    = (digi != exp_digi);
    sel_change  = (sel != prev_sel_q);
    frame_start = (prev_sel_q == SEL_LAST) && (sel == SEL_FIRST);
    commit      = frame_start && pending_o;

    if (sel_change) begin
      blank_now     = BLANK_EN;
      blank_cnt_nxt = BLANK_LOAD;
    end else if (blank_cnt_q != '0) begin
      blank_now     = 1'b1;
      blank_cnt_nxt = blank_cnt_q - CNT_W'(1);
    end else begin
      blank_now     = 1'b0;
      blank_cnt_nxt = '0;
    end

    // The digit driven on the commit edge already shows the newly committed value.
    disp_nxt    = commit ? pend_q : disp_q;
    disp_dp_nxt = commit ? pend_dp_q : disp_dp_q;
    nibble      = disp_nxt[{digit_idx, 2'b00} +: 4];
    dp_req      = disp_dp_nxt[digit_idx];
    seg_lit     = SEG_ACTIVE_LOW ? hex_seg_n(nibble) : ~hex_seg_n(nibble);
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is a leading zero while it and every higher digit are 0 with no decimal point.
  always_comb begin
    lz_mask    = '0;
    lz_mask[3] = (disp_nxt[15:12] == 4'h0) && !disp_dp_nxt[3];
    lz_mask[2] = lz_mask[3] && (disp_nxt[11:8] == 4'h0) && !disp_dp_nxt[2];
    lz_mask[1] = lz_mask[2] && (disp_nxt[7:4] == 4'h0) && !disp_dp_nxt[1];
    lz_hide    = lz_mask[digit_idx];
  end
`else
  always_comb begin
    lz_mask = '0;
    lz_hide = lz_mask[digit_idx];
  end
`endif

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      disp_q      <= '0;
      disp_dp_q   <= '0;
      pend_q      <= '0;
      pend_dp_q   <= '0;
      pending_o   <= 1'b0;
      prev_sel_q  <= SEL_LAST;
      blank_cnt_q <= '0;
      err_o       <= 1'b0;
      an_o        <= '0;
      seg_o       <= SEG_OFF;
      dp_o        <= DP_OFF;
    end else begin
      prev_sel_q  <= sel;
      blank_cnt_q <= blank_cnt_nxt;
      disp_q      <= disp_nxt;
      disp_dp_q   <= disp_dp_nxt;

      // A load on the commit edge refills the buffer just emptied, so pending stays set.
      if (load_i) begin
        pend_q    <= data_i;
        pend_dp_q <= dp_i;
        pending_o <= 1'b1;
      end else if (commit) begin
        pending_o <= 1'b0;
      end

      if (mismatch) begin
        err_o <= 1'b1;
      end

      if (mismatch || blank_now) begin
        an_o  <= '0;
        seg_o <= SEG_OFF;
        dp_o  <= DP_OFF;
      end else begin
        an_o  <= digi;
        seg_o <= lz_hide ? SEG_OFF : seg_lit;
        dp_o  <= (dp_req && !lz_hide) ? ~DP_OFF : DP_OFF;
      end
    end
  end

endmodule
